regfile_wb_arbiter: RTL and testbench

Write-side front end for the 32×32 register file. It accepts results from two producers, the single-cycle ALU path and the multi-cycle load path, each over a valid/ready handshake. It arbitrates them onto the register file's single write port (`addrD`/`dataD`/`wEn`). Load results are buffered in a small FIFO, and a starvation limiter guarantees loads eventually win over a continuously busy ALU.

---
 rtl/regfile_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-side front end for the 32x32 register file. Two producers feed the
// register file's single write port:
//   - ALU path  : single-cycle results. It has priority and is never buffered.
//   - Load path : multi-cycle results. They are buffered in a DEPTH-entry FIFO
//                 and popped whenever the ALU is not writing.
// A starvation counter caps the number of consecutive ALU wins while loads are
// waiting. When the cap is reached, alu_ready drops for one cycle so that the
// FIFO head can pop.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data       ALU result offer
//   alu_ready                       ALU result taken (alu_valid & alu_ready)
//   mem_valid/mem_rd/mem_data       load result offer
//   mem_ready                       load FIFO has room
//   addrD/dataD/wEn                 registered register-file write port
//   fifo_count                      load FIFO occupancy
// Writes to x0 are accepted from either producer and then dropped.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [31:0]              mem_data,
  output logic                     mem_ready,
  output logic [4:0]               addrD,
  output logic [31:0]              dataD,
  output logic                     wEn,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // FIFO storage and bookkeeping
  logic [36:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Starvation counter and write-port registers
  logic [3:0]    scnt_q,   scnt_d;
  logic [4:0]    addr_q,   addr_d;
  logic [31:0]   data_q,   data_d;
  logic          wen_q,    wen_d;

  logic          fifo_ne;
  logic          alu_wr;
  logic          push;
  logic          pop;
  logic [36:0]   head;

  // Both readies depend only on registered state. They never see the valids.
  assign alu_ready = (scnt_q != 4'(STARVE_MAX));
  assign mem_ready = (count_q < CW'(DEPTH));

  assign fifo_ne = (count_q != '0);
  assign alu_wr  = alu_valid & alu_ready & (alu_rd != 5'd0);
  // A full FIFO refuses the push even if a pop happens in the same cycle.
  assign push    = mem_valid & mem_ready & (mem_rd != 5'd0);
  // An x0 ALU handshake is not a write, so the head may pop in that cycle.
  assign pop     = fifo_ne & ~alu_wr;
  assign head    = mem_q[rd_ptr_q];

  // NOTE: always_comb gives every output a default first. A path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    scnt_d   = '0;
    addr_d   = addr_q;
    data_d   = data_q;
    wen_d    = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    // A simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (alu_wr) begin
      wen_d  = 1'b1;
      addr_d = alu_rd;
      data_d = alu_data;
      // Count only the wins that make a waiting load wait longer.
      scnt_d = fifo_ne ? scnt_q + 4'd1 : 4'd0;
    end else if (pop) begin
      wen_d  = 1'b1;
      addr_d = head[36:32];
      data_d = head[31:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments. Every register
  // then samples pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      scnt_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wen_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      scnt_q   <= scnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wen_q    <= wen_d;
    end
  end

  // NOTE: the storage array has no reset. An entry is read only after it has
  // been pushed, because count_q and the pointers guard every read. This also
  // lets the array map onto plain RAM or unreset flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {mem_rd, mem_data};
  end

  assign addrD      = addr_q;
  assign dataD      = data_q;
  assign wEn        = wen_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Self-checking bench for regfile_wb_arbiter, run with DEPTH=4 and
// STARVE_MAX=3. The sequence is:
//   1. reset-state checks
//   2. a table of hand-derived vectors: ALU only, load only, starvation, x0
//   3. hand-written sequences: FIFO full and ordering, async reset mid-stream
//   4. random traffic checked against a queue-based reference model
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  addrD;
  logic [31:0] dataD;
  logic        wEn;
  logic [2:0]  fifo_count;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .addrD      (addrD),
    .dataD      (dataD),
    .wEn        (wEn),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of pending loads plus a count of ALU wins
  // ---------------------------------------------------------------------------
  typedef struct { logic [4:0] rd; logic [31:0] data; } load_t;
  load_t       m_q[$];
  int          m_scnt;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic model_reset();
    m_q.delete();
    m_scnt = 0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // The bench enters each cycle just after a rising edge. It drives the
  // inputs, checks the readies, lets the edge happen and then checks the
  // write port against the model.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
    bit    a_rdy, m_rdy, had;
    load_t e;
    alu_valid = av;  alu_rd = ard;  alu_data = adata;
    mem_valid = mv;  mem_rd = mrd;  mem_data = mdata;
    a_rdy = (m_scnt != SMAX);
    m_rdy = (m_q.size() < DEPTH);
    #1;
    check("alu_ready", 64'(alu_ready), 64'(a_rdy));
    check("mem_ready", 64'(mem_ready), 64'(m_rdy));
    had = (m_q.size() != 0);
    if (av && a_rdy && ard != 0) begin
      m_wen = 1'b1;  m_addr = ard;  m_data = adata;
      m_scnt = had ? m_scnt + 1 : 0;
    end else if (had) begin
      e = m_q.pop_front();
      m_wen = 1'b1;  m_addr = e.rd;  m_data = e.data;
      m_scnt = 0;
    end else begin
      m_wen = 1'b0;
      m_scnt = 0;
    end
    if (mv && m_rdy && mrd != 0) m_q.push_back('{rd: mrd, data: mdata});
    @(posedge clk);
    #1;
    check("wEn", 64'(wEn), 64'(m_wen));
    check("addrD", 64'(addrD), 64'(m_addr));
    check("dataD", 64'(dataD), 64'(m_data));
    check("fifo_count", 64'(fifo_count), 64'(m_q.size()));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table. The readies are expected before the edge; the write port
  // and fifo_count are expected after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] adata;
    logic        mv;  logic [4:0] mrd; logic [31:0] mdata;
    logic        e_ardy; logic e_mrdy;
    logic        e_wen;  logic [4:0] e_addr; logic [31:0] e_data; logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [3:0] seen[$];
    int         k;
    int         accepted;

    // av ard  adata         mv mrd mdata         ardy mrdy wen addr data          cnt
    vecs[0]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        0}; // idle
    vecs[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        1, 1, 1, 5, 32'hDEADBEEF, 0}; // ALU only
    vecs[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 5, 32'hDEADBEEF, 0};
    vecs[3]  = '{0, 0, 32'h0,        1, 7, 32'h12345678, 1, 1, 0, 5, 32'hDEADBEEF, 1}; // load only
    vecs[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 1, 7, 32'h12345678, 0};
    vecs[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 7, 32'h12345678, 0};
    vecs[6]  = '{0, 0, 32'h0,        1, 3, 32'hA5,       1, 1, 0, 7, 32'h12345678, 1}; // starvation
    vecs[7]  = '{1, 1, 32'h11,       0, 0, 32'h0,        1, 1, 1, 1, 32'h11,       1};
    vecs[8]  = '{1, 2, 32'h22,       0, 0, 32'h0,        1, 1, 1, 2, 32'h22,       1};
    vecs[9]  = '{1, 3, 32'h33,       0, 0, 32'h0,        1, 1, 1, 3, 32'h33,       1};
    vecs[10] = '{1, 4, 32'h44,       0, 0, 32'h0,        0, 1, 1, 3, 32'hA5,       0};
    vecs[11] = '{1, 4, 32'h44,       0, 0, 32'h0,        1, 1, 1, 4, 32'h44,       0};
    vecs[12] = '{1, 0, 32'h99,       1, 0, 32'h77,       1, 1, 0, 4, 32'h44,       0}; // x0 discard
    vecs[13] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 4, 32'h44,       0};
    vecs[14] = '{0, 0, 32'h0,        1, 9, 32'h900,      1, 1, 0, 4, 32'h44,       1};
    vecs[15] = '{1, 0, 32'h55,       0, 0, 32'h0,        1, 1, 1, 9, 32'h900,      0}; // x0 lets pop

    // ---- reset state, checked while reset is still asserted ----
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    #12;
    check("rst wEn", 64'(wEn), 64'd0);
    check("rst addrD", 64'(addrD), 64'd0);
    check("rst dataD", 64'(dataD), 64'd0);
    check("rst fifo_count", 64'(fifo_count), 64'd0);
    check("rst alu_ready", 64'(alu_ready), 64'd1);
    check("rst mem_ready", 64'(mem_ready), 64'd1);
    do_reset();

    // ---- table-driven vectors ----
    for (int i = 0; i < 16; i++) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adata;
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].mdata;
      #1;
      check($sformatf("vec%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_ardy));
      check($sformatf("vec%0d mem_ready", i), 64'(mem_ready), 64'(vecs[i].e_mrdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d wEn", i), 64'(wEn), 64'(vecs[i].e_wen));
      check($sformatf("vec%0d addrD", i), 64'(addrD), 64'(vecs[i].e_addr));
      check($sformatf("vec%0d dataD", i), 64'(dataD), 64'(vecs[i].e_data));
      check($sformatf("vec%0d fifo_count", i), 64'(fifo_count), 64'(vecs[i].e_cnt));
    end

    // ---- FIFO full: busy ALU, 5 loads held by the producer until taken ----
    do_reset();
    k = 1;
    accepted = 0;
    for (int c = 0; c < 60; c++) begin
      bit take;
      take = (k <= 5) && (m_q.size() < DEPTH);
      cycle(1'b1, 5'(1 + c % 20), 32'hA000_0000 | 32'(c),
            k <= 5, 5'(10 + k), 32'h1D00_0000 | 32'(k));
      if (take) begin
        k++;
        accepted++;
        if (accepted == DEPTH) begin
          check("full fifo_count", 64'(fifo_count), 64'(DEPTH));
          check("full mem_ready", 64'(mem_ready), 64'd0);
        end
      end
      if (wEn && dataD[31:4] == 28'h1D00000) seen.push_back(dataD[3:0]);
      if (seen.size() == 5) break;
    end
    check("full loads drained", 64'(seen.size()), 64'd5);
    for (int i = 0; i < seen.size(); i++)
      check($sformatf("full order %0d", i), 64'(seen[i]), 64'(i + 1));

    // ---- async reset with fifo_count=3 and wEn=1 ----
    do_reset();
    for (int c = 0; c < 3; c++)
      cycle(1'b1, 5'(20 + c), 32'hB0 + 32'(c), 1'b1, 5'(12 + c), 32'hC0 + 32'(c));
    check("pre-rst fifo_count", 64'(fifo_count), 64'd3);
    check("pre-rst wEn", 64'(wEn), 64'd1);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("async wEn", 64'(wEn), 64'd0);
    check("async fifo_count", 64'(fifo_count), 64'd0);
    check("async addrD", 64'(addrD), 64'd0);
    check("async dataD", 64'(dataD), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    check("post-rst wEn", 64'(wEn), 64'd1);
    check("post-rst dataD", 64'(dataD), 64'hDEADBEEF);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // ---- random traffic against the model ----
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 9) < 5, 5'($urandom_range(0, 31)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
